// File: rtl/alu_arbiter_if.sv
// Bundle of signals between two requesters, the arbiter, the shared ALU and the consumer.
// slave modport: arbiter side (alu_arbiter). master modport: environment side
// (requesters, shared ALU, response consumer).
interface alu_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic             req0_ready;
  logic [2:0]       req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;

  logic             req1_valid;
  logic             req1_ready;
  logic [2:0]       req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic [2:0]       alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_result;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_err;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  alu_result, rsp_ready,
    output req0_ready, req1_ready,
    output alu_op, alu_a, alu_b,
    output rsp_valid, rsp_id, rsp_result, rsp_err
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output alu_result, rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_op, alu_a, alu_b,
    input  rsp_valid, rsp_id, rsp_result, rsp_err
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Latency: accept edge N, result captured edge N+1, rsp_valid high after it; issue interval >= 3 cycles.
// Backpressure: the response is held in RESP until rsp_ready; no request is accepted meanwhile.
// Ports: clk, rst_n (async active-low), bus (alu_arbiter_if.slave: req0/1 valid-ready
// channels, ALU drive/result, response valid-ready channel).
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus
);

  localparam logic [2:0] OP_ILLEGAL = 3'b111;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             last_grant;
  logic             grant;
  logic             grant_id;
  logic             lat_id;
  logic [2:0]       lat_op;
  logic [WIDTH-1:0] lat_a;
  logic [WIDTH-1:0] lat_b;
  logic             lat_illegal;

  assign lat_illegal = (lat_op == OP_ILLEGAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    grant          = 1'b0;
    grant_id       = 1'b0;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.alu_op     = 3'b000;
    bus.alu_a      = '0;
    bus.alu_b      = '0;
    bus.rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        // rst_n gates the grant so no ready escapes while reset is held.
        if (rst_n && (bus.req0_valid || bus.req1_valid)) begin
          grant = 1'b1;
          // Contention goes to whoever was not granted last; a lone requester always wins.
          if (bus.req0_valid && bus.req1_valid) begin
            grant_id = ~last_grant;
          end else begin
            grant_id = bus.req1_valid;
          end
          bus.req0_ready = ~grant_id;
          bus.req1_ready = grant_id;
          state_nxt      = EXEC;
        end
      end
      EXEC: begin
        // An illegal opcode leaves the ALU parked at add 0,0.
        if (!lat_illegal) begin
          bus.alu_op = lat_op;
          bus.alu_a  = lat_a;
          bus.alu_b  = lat_b;
        end
        state_nxt = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant     <= 1'b1;
      lat_id         <= 1'b0;
      lat_op         <= 3'b000;
      lat_a          <= '0;
      lat_b          <= '0;
      bus.rsp_id     <= 1'b0;
      bus.rsp_result <= '0;
      bus.rsp_err    <= 1'b0;
    end else begin
      if (grant) begin
        last_grant <= grant_id;
        lat_id     <= grant_id;
        lat_op     <= grant_id ? bus.req1_op : bus.req0_op;
        lat_a      <= grant_id ? bus.req1_a  : bus.req0_a;
        lat_b      <= grant_id ? bus.req1_b  : bus.req0_b;
      end
      if (state == EXEC) begin
        bus.rsp_id     <= lat_id;
        bus.rsp_result <= lat_illegal ? '0 : bus.alu_result;
        bus.rsp_err    <= lat_illegal;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: drives inputs on the falling edge, checks 1 ns later.
// Latency: n/a. Backpressure: rsp_ready driven directly by the stimulus.
// A behavioural shared ALU answers the arbiter's ALU drive combinationally.
module tb_alu_arbiter;

  localparam int WIDTH = 32;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  alu_arbiter_if #(.WIDTH(WIDTH)) bus ();

  alu_arbiter #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU model.
  always_comb begin
    bus.alu_result = '0;
    case (bus.alu_op)
      3'b000: bus.alu_result = bus.alu_a + bus.alu_b;
      3'b001: bus.alu_result = bus.alu_a - bus.alu_b;
      3'b010: bus.alu_result = bus.alu_a | bus.alu_b;
      3'b011: bus.alu_result = bus.alu_a & bus.alu_b;
      3'b100: bus.alu_result = bus.alu_a ^ bus.alu_b;
      3'b101: bus.alu_result = {31'd0, ($signed(bus.alu_a) < $signed(bus.alu_b))};
      3'b110: bus.alu_result = {31'd0, (bus.alu_a < bus.alu_b)};
      default: bus.alu_result = '0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Every cycle: never two readys, and the ALU is parked whenever a response is held.
  always @(negedge clk) begin
    #2;
    chk("one_ready", {31'd0, bus.req0_ready & bus.req1_ready}, 32'd0);
    if (bus.rsp_valid) begin
      chk("alu_op_idle_rsp", {29'd0, bus.alu_op}, 32'd0);
      chk("alu_a_idle_rsp", bus.alu_a, 32'd0);
      chk("alu_b_idle_rsp", bus.alu_b, 32'd0);
    end
  end

  initial begin
    logic [2:0]  op_t [2];
    logic [31:0] a_t  [2];
    logic [31:0] b_t  [2];
    logic [31:0] r_t  [2];
    int          id;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req0_op = 3'b000; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b0;
    bus.req1_op = 3'b000; bus.req1_a = '0; bus.req1_b = '0;
    bus.rsp_ready = 1'b1;

    // Reset state, with a request pending that must not be granted.
    cyc(); #1;
    chk("rst_ready0", {31'd0, bus.req0_ready}, 32'd0);
    chk("rst_ready1", {31'd0, bus.req1_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_id", {31'd0, bus.rsp_id}, 32'd0);
    chk("rst_rsp_result", bus.rsp_result, 32'd0);
    chk("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    chk("rst_alu_op", {29'd0, bus.alu_op}, 32'd0);
    bus.req0_valid = 1'b0;

    // Single request from req0: 5 + 6.
    cyc(); rst_n = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_op = 3'b000; bus.req0_a = 32'd5; bus.req0_b = 32'd6;
    #1;
    chk("t1_ready0", {31'd0, bus.req0_ready}, 32'd1);
    chk("t1_ready1", {31'd0, bus.req1_ready}, 32'd0);
    cyc(); bus.req0_valid = 1'b0; #1;
    chk("t1_exec_ready0", {31'd0, bus.req0_ready}, 32'd0);
    chk("t1_exec_alu_op", {29'd0, bus.alu_op}, 32'd0);
    chk("t1_exec_alu_a", bus.alu_a, 32'd5);
    chk("t1_exec_alu_b", bus.alu_b, 32'd6);
    chk("t1_exec_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    cyc(); #1;
    chk("t1_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    chk("t1_rsp_id", {31'd0, bus.rsp_id}, 32'd0);
    chk("t1_rsp_result", bus.rsp_result, 32'd11);
    chk("t1_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    chk("t1_rsp_alu_a", bus.alu_a, 32'd0);
    cyc(); #1;
    chk("t1_idle_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);

    // Fresh reset so the pointer is back at 1, then both requesters hold valid.
    cyc(); rst_n = 1'b0;
    cyc(); rst_n = 1'b1;
    op_t[0] = 3'b001; a_t[0] = 32'd7;          b_t[0] = 32'd3; r_t[0] = 32'd4;
    op_t[1] = 3'b101; a_t[1] = 32'hFFFF_FFFA;  b_t[1] = 32'd4; r_t[1] = 32'd1;
    bus.req0_valid = 1'b1; bus.req0_op = op_t[0]; bus.req0_a = a_t[0]; bus.req0_b = b_t[0];
    bus.req1_valid = 1'b1; bus.req1_op = op_t[1]; bus.req1_a = a_t[1]; bus.req1_b = b_t[1];
    for (int k = 0; k < 3; k++) begin
      id = k % 2;
      #1;
      chk("t2_ready0", {31'd0, bus.req0_ready}, {31'd0, id == 0});
      chk("t2_ready1", {31'd0, bus.req1_ready}, {31'd0, id == 1});
      cyc();
      if (k == 2) begin
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
      end
      #1;
      chk("t2_exec_alu_op", {29'd0, bus.alu_op}, {29'd0, op_t[id]});
      chk("t2_exec_alu_a", bus.alu_a, a_t[id]);
      chk("t2_exec_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      cyc(); #1;
      chk("t2_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      chk("t2_rsp_id", {31'd0, bus.rsp_id}, id);
      chk("t2_rsp_result", bus.rsp_result, r_t[id]);
      cyc();
    end
    #1;
    chk("t2_idle_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("t2_idle_ready0", {31'd0, bus.req0_ready}, 32'd0);

    // Backpressure: req1 sltu 5,6 held for five cycles while req0 waits.
    cyc();
    bus.rsp_ready = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_op = 3'b110; bus.req1_a = 32'd5; bus.req1_b = 32'd6;
    #1;
    chk("t3_ready1", {31'd0, bus.req1_ready}, 32'd1);
    chk("t3_ready0", {31'd0, bus.req0_ready}, 32'd0);
    cyc();
    bus.req1_valid = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_op = 3'b000; bus.req0_a = 32'd1; bus.req0_b = 32'd2;
    #1;
    chk("t3_exec_ready0", {31'd0, bus.req0_ready}, 32'd0);
    repeat (5) begin
      cyc(); #1;
      chk("t3_hold_valid", {31'd0, bus.rsp_valid}, 32'd1);
      chk("t3_hold_id", {31'd0, bus.rsp_id}, 32'd1);
      chk("t3_hold_result", bus.rsp_result, 32'd1);
      chk("t3_hold_ready0", {31'd0, bus.req0_ready}, 32'd0);
    end
    cyc(); bus.rsp_ready = 1'b1; #1;
    chk("t3_release_valid", {31'd0, bus.rsp_valid}, 32'd1);
    chk("t3_release_ready0", {31'd0, bus.req0_ready}, 32'd0);
    cyc(); #1;
    chk("t3_after_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("t3_after_ready0", {31'd0, bus.req0_ready}, 32'd1);
    cyc(); bus.req0_valid = 1'b0; #1;
    chk("t3_r0_alu_a", bus.alu_a, 32'd1);
    chk("t3_r0_alu_b", bus.alu_b, 32'd2);
    cyc(); #1;
    chk("t3_r0_result", bus.rsp_result, 32'd3);
    chk("t3_r0_id", {31'd0, bus.rsp_id}, 32'd0);

    // Illegal opcode from req0.
    cyc();
    bus.req0_valid = 1'b1; bus.req0_op = 3'b111; bus.req0_a = 32'd3; bus.req0_b = 32'd5;
    #1;
    chk("t4_ready0", {31'd0, bus.req0_ready}, 32'd1);
    cyc(); bus.req0_valid = 1'b0; #1;
    chk("t4_exec_alu_op", {29'd0, bus.alu_op}, 32'd0);
    chk("t4_exec_alu_a", bus.alu_a, 32'd0);
    chk("t4_exec_alu_b", bus.alu_b, 32'd0);
    chk("t4_exec_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    cyc(); #1;
    chk("t4_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    chk("t4_rsp_err", {31'd0, bus.rsp_err}, 32'd1);
    chk("t4_rsp_result", bus.rsp_result, 32'd0);
    chk("t4_rsp_id", {31'd0, bus.rsp_id}, 32'd0);
    cyc(); #1;
    chk("t4_idle_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);

    // Reset in the middle of EXEC, then a lone req1 xor right after release.
    bus.req0_valid = 1'b1; bus.req0_op = 3'b000; bus.req0_a = 32'd9; bus.req0_b = 32'd9;
    #1;
    chk("t5_ready0", {31'd0, bus.req0_ready}, 32'd1);
    cyc(); bus.req0_valid = 1'b0; #1;
    chk("t5_exec_alu_a", bus.alu_a, 32'd9);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_alu_op", {29'd0, bus.alu_op}, 32'd0);
    chk("t5_rst_alu_a", bus.alu_a, 32'd0);
    chk("t5_rst_alu_b", bus.alu_b, 32'd0);
    chk("t5_rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("t5_rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    chk("t5_rst_rsp_result", bus.rsp_result, 32'd0);
    chk("t5_rst_rsp_id", {31'd0, bus.rsp_id}, 32'd0);
    chk("t5_rst_ready0", {31'd0, bus.req0_ready}, 32'd0);
    cyc(); #1;
    chk("t5_rst_hold_valid", {31'd0, bus.rsp_valid}, 32'd0);
    cyc(); rst_n = 1'b1;
    bus.req1_valid = 1'b1; bus.req1_op = 3'b100; bus.req1_a = 32'd5; bus.req1_b = 32'd2;
    #1;
    chk("t5_ready1", {31'd0, bus.req1_ready}, 32'd1);
    cyc(); bus.req1_valid = 1'b0; #1;
    chk("t5_exec_alu_op", {29'd0, bus.alu_op}, 32'd4);
    cyc(); #1;
    chk("t5_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    chk("t5_rsp_result", bus.rsp_result, 32'd7);
    chk("t5_rsp_id", {31'd0, bus.rsp_id}, 32'd1);
    chk("t5_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    cyc(); #1;
    chk("t5_idle_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
